// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the write-back entry type carried through the
// long-latency result buffer.
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] rd);
    return rd == '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding long-latency write-back results.
// Pointers wrap naturally because DEPTH is a power of two.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_scoreboard_rv32i.sv
// Register-file write-back arbiter (ALU first, then buffered long-latency
// results) plus the busy-register scoreboard that drives the decode stall.
module wb_scoreboard_rv32i #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ll_issue,
  input  logic [4:0]      ll_issue_rd,
  input  logic            ll_valid,
  output logic            ll_ready,
  input  logic [4:0]      ll_rd,
  input  logic [XLEN-1:0] ll_data,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic [4:0]      dec_rd,
  output logic            stall,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     busy
);

  import rv32i_pkg::*;

  wb_entry_t   push_entry;
  wb_entry_t   head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic [31:0] busy_next;

  assign ll_ready   = reset_n && !fifo_full;
  assign push       = ll_valid && ll_ready;
  assign pop        = !alu_valid && !fifo_empty;
  assign push_entry = '{rd: ll_rd, data: ll_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(wb_entry_t))
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .din     (push_entry),
    .pop     (pop),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // busy[0] is held at zero, so x0 operands never stall.
  assign stall = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd] | fifo_full;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (alu_valid) begin
      rf_we    <= !is_x0(alu_rd);
      rf_waddr <= alu_rd;
      rf_wdata <= alu_data;
    end else if (!fifo_empty) begin
      rf_we    <= !is_x0(head.rd);
      rf_waddr <= head.rd;
      rf_wdata <= head.data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Clear on the edge the register file captures; a same-edge issue wins.
  always_comb begin
    busy_next = busy;
    if (rf_we) begin
      busy_next[rf_waddr] = 1'b0;
    end
    if (ll_issue && !stall && !is_x0(ll_issue_rd)) begin
      busy_next[ll_issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_wb_scoreboard_rv32i.sv
// Bench for wb_scoreboard_rv32i: a directed vector table for the corner
// cases, then random traffic against a queue-based reference model.
module tb_wb_scoreboard_rv32i;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ll_issue;
  logic [4:0]  ll_issue_rd;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  wb_scoreboard_rv32i #(.XLEN(32), .FIFO_DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ll_issue    (ll_issue),
    .ll_issue_rd (ll_issue_rd),
    .ll_valid    (ll_valid),
    .ll_ready    (ll_ready),
    .ll_rd       (ll_rd),
    .ll_data     (ll_data),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_rd      (dec_rd),
    .stall       (stall),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy        (busy)
  );

  typedef struct {
    bit [31:0] rst_n, alu_v, alu_rd, alu_d, iss, iss_rd, llv, ll_rd, ll_d;
    bit [31:0] rs1, rs2, rd;
    bit [31:0] e_ready, e_stall, e_we, e_chk, e_waddr, e_wdata, e_busy;
  } vec_t;

  typedef struct {
    bit [4:0]  rd;
    bit [31:0] data;
  } ent_t;

  vec_t      tbl [30];
  ent_t      m_q [$];
  bit [31:0] m_busy;
  bit        m_we;
  bit [4:0]  m_waddr;
  bit [31:0] m_wdata;
  bit        m_after_rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    reset_n     = v.rst_n[0];
    alu_valid   = v.alu_v[0];
    alu_rd      = v.alu_rd[4:0];
    alu_data    = v.alu_d;
    ll_issue    = v.iss[0];
    ll_issue_rd = v.iss_rd[4:0];
    ll_valid    = v.llv[0];
    ll_rd       = v.ll_rd[4:0];
    ll_data     = v.ll_d;
    dec_rs1     = v.rs1[4:0];
    dec_rs2     = v.rs2[4:0];
    dec_rd      = v.rd[4:0];
  endtask

  function automatic bit model_stall(input bit [4:0] a, input bit [4:0] b, input bit [4:0] c);
    return m_busy[a] || m_busy[b] || m_busy[c] || (m_q.size() == DEPTH);
  endfunction

  // Reference: applies the write-back and scoreboard rules for one edge.
  task automatic model_edge(input bit st_pre);
    bit [31:0] nb;
    bit        push_ok;
    ent_t      e;
    if (!reset_n) begin
      m_q.delete();
      m_busy = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
      m_after_rst = 1;
      return;
    end
    m_after_rst = 0;
    nb = m_busy;
    if (m_we) nb[m_waddr] = 0;
    if (ll_issue && !st_pre && ll_issue_rd != 0) nb[ll_issue_rd] = 1;
    push_ok = ll_valid && (m_q.size() < DEPTH);
    if (alu_valid) begin
      m_we = (alu_rd != 0); m_waddr = alu_rd; m_wdata = alu_data;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_we = (e.rd != 0); m_waddr = e.rd; m_wdata = e.data;
    end else begin
      m_we = 0;
    end
    if (push_ok) begin
      e.rd = ll_rd; e.data = ll_data;
      m_q.push_back(e);
    end
    m_busy = nb;
  endtask

  initial begin
    vec_t idle;
    idle = '{1,0,0,0,0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0};
    drive(idle);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);

    //            rst alu rd  data        iss rd  llv rd data   rs1 rs2 rd  rdy stl we chk wa wd          busy
    tbl[0]  = '{1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0,       0, 0, 0,  1, 0, 1, 1, 5, 32'hDEADBEEF, 0};
    tbl[1]  = '{1, 0, 0, 0,            1, 7, 0, 0, 0,       0, 0, 0,  1, 0, 0, 0, 0, 0, 32'h80};
    tbl[2]  = '{1, 0, 0, 0,            0, 0, 0, 0, 0,       7, 0, 0,  1, 1, 0, 0, 0, 0, 32'h80};
    tbl[3]  = '{1, 0, 0, 0,            0, 0, 1, 7, 32'h1234, 7, 0, 0, 1, 1, 0, 0, 0, 0, 32'h80};
    tbl[4]  = '{1, 0, 0, 0,            0, 0, 0, 0, 0,       7, 0, 0,  1, 1, 1, 1, 7, 32'h1234, 32'h80};
    tbl[5]  = '{1, 0, 0, 0,            0, 0, 0, 0, 0,       7, 0, 0,  1, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 0,            0, 0, 0, 0, 0,       7, 0, 0,  1, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 1, 1, 32'h11,       0, 0, 1, 2, 32'h22,  0, 0, 0,  1, 0, 1, 1, 1, 32'h11, 0};
    tbl[8]  = '{1, 1, 3, 32'h33,       0, 0, 1, 4, 32'h44,  0, 0, 0,  1, 0, 1, 1, 3, 32'h33, 0};
    tbl[9]  = '{1, 1, 5, 32'h55,       0, 0, 1, 6, 32'h66,  0, 0, 0,  0, 1, 1, 1, 5, 32'h55, 0};
    tbl[10] = '{1, 0, 0, 0,            0, 0, 0, 0, 0,       0, 0, 0,  0, 1, 1, 1, 2, 32'h22, 0};
    tbl[11] = '{1, 0, 0, 0,            0, 0, 0, 0, 0,       0, 0, 0,  1, 0, 1, 1, 4, 32'h44, 0};
    tbl[12] = '{1, 0, 0, 0,            0, 0, 0, 0, 0,       0, 0, 0,  1, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{1, 1, 0, 32'h99,       1, 0, 1, 0, 32'h77,  0, 0, 0,  1, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{1, 0, 0, 0,            0, 0, 0, 0, 0,       0, 0, 0,  1, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{1, 0, 0, 0,            0, 0, 0, 0, 0,       0, 0, 0,  1, 0, 0, 0, 0, 0, 0};
    tbl[16] = '{1, 0, 0, 0,            1, 9, 0, 0, 0,       0, 0, 0,  1, 0, 0, 0, 0, 0, 32'h200};
    tbl[17] = '{1, 1, 9, 32'hA9,       0, 0, 0, 0, 0,       0, 9, 0,  1, 1, 1, 1, 9, 32'hA9, 32'h200};
    tbl[18] = '{1, 0, 0, 0,            1, 9, 0, 0, 0,       0, 0, 0,  1, 0, 0, 0, 0, 0, 32'h200};
    tbl[19] = '{1, 0, 0, 0,            0, 0, 1, 9, 32'hB9,  0, 0, 0,  1, 0, 0, 0, 0, 0, 32'h200};
    tbl[20] = '{1, 0, 0, 0,            0, 0, 0, 0, 0,       0, 0, 9,  1, 1, 1, 1, 9, 32'hB9, 32'h200};
    tbl[21] = '{1, 0, 0, 0,            0, 0, 0, 0, 0,       0, 0, 9,  1, 1, 0, 0, 0, 0, 0};
    tbl[22] = '{1, 0, 0, 0,            1, 7, 0, 0, 0,       0, 0, 0,  1, 0, 0, 0, 0, 0, 32'h80};
    tbl[23] = '{1, 1, 1, 1,            1, 9, 1, 3, 3,       0, 0, 0,  1, 0, 1, 1, 1, 1, 32'h280};
    tbl[24] = '{1, 1, 1, 2,            0, 0, 1, 4, 4,       0, 0, 0,  1, 0, 1, 1, 1, 2, 32'h280};
    tbl[25] = '{0, 0, 0, 0,            0, 0, 1, 5, 5,       0, 0, 0,  0, 1, 0, 1, 0, 0, 0};
    tbl[26] = '{0, 0, 0, 0,            0, 0, 0, 0, 0,       0, 0, 0,  0, 0, 0, 1, 0, 0, 0};
    tbl[27] = '{1, 0, 0, 0,            0, 0, 0, 0, 0,       7, 9, 0,  1, 0, 0, 0, 0, 0, 0};
    tbl[28] = '{1, 0, 0, 0,            0, 0, 1, 8, 32'h88,  0, 0, 0,  1, 0, 0, 0, 0, 0, 0};
    tbl[29] = '{1, 0, 0, 0,            0, 0, 0, 0, 0,       0, 0, 0,  1, 0, 1, 1, 8, 32'h88, 0};

    for (int i = 0; i < 30; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d ll_ready", i), {31'b0, ll_ready}, tbl[i].e_ready);
      chk($sformatf("v%0d stall", i), {31'b0, stall}, tbl[i].e_stall);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d rf_we", i), {31'b0, rf_we}, tbl[i].e_we);
      chk($sformatf("v%0d busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_chk[0]) begin
        chk($sformatf("v%0d rf_waddr", i), {27'b0, rf_waddr}, tbl[i].e_waddr);
        chk($sformatf("v%0d rf_wdata", i), rf_wdata, tbl[i].e_wdata);
      end
      @(negedge clock);
    end

    // Random phase: start both DUT and model from reset.
    drive(idle);
    reset_n = 1'b0;
    model_edge(1'b0);
    @(posedge clock);
    @(negedge clock);

    for (int c = 0; c < 3000; c++) begin
      bit st;
      reset_n     = ($urandom_range(0, 63) != 0);
      alu_valid   = $urandom_range(0, 1) == 1;
      alu_rd      = 5'($urandom_range(0, 7));
      alu_data    = $urandom;
      ll_valid    = $urandom_range(0, 1) == 1;
      ll_rd       = 5'($urandom_range(0, 7));
      ll_data     = $urandom;
      dec_rs1     = 5'($urandom_range(0, 7));
      dec_rs2     = 5'($urandom_range(0, 7));
      dec_rd      = 5'($urandom_range(0, 7));
      st          = model_stall(dec_rs1, dec_rs2, dec_rd);
      ll_issue    = !st && ($urandom_range(0, 2) == 0);
      ll_issue_rd = 5'($urandom_range(0, 7));
      #1;
      chk("rnd ll_ready", {31'b0, ll_ready}, {31'b0, reset_n && (m_q.size() < DEPTH)});
      chk("rnd stall", {31'b0, stall}, {31'b0, st});
      @(posedge clock);
      model_edge(st);
      #1;
      chk("rnd rf_we", {31'b0, rf_we}, {31'b0, m_we});
      chk("rnd busy", busy, m_busy);
      if (m_we || m_after_rst) begin
        chk("rnd rf_waddr", {27'b0, rf_waddr}, {27'b0, m_waddr});
        chk("rnd rf_wdata", rf_wdata, m_wdata);
      end
      @(negedge clock);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_scoreboard_rv32i.md
# wb_scoreboard_rv32i

Write-back arbiter and register scoreboard for the RV32I core: the writer side of the 32x32 register file. Merges single-cycle ALU results with long-latency results (load/mul) buffered in a small FIFO. Drives the register file write port with registered signals. Tracks destination registers of in-flight long-latency ops and raises a decode stall on RAW/WAW hazards.

## Interface
- XLEN, 32, data width
- FIFO_DEPTH, 2, long-latency result buffer entries (power of two, >=2)

- clock  in  1  global clock, all state updates on posedge
- reset_n  in  1  synchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination
- alu_data  in  XLEN  ALU result
- ll_issue  in  1  decode issues a long-latency op this cycle
- ll_issue_rd  in  5  its destination
- ll_valid  in  1  long-latency unit offers a result
- ll_ready  out  1  FIFO can accept; transfer when ll_valid && ll_ready
- ll_rd  in  5  result destination
- ll_data  in  XLEN  result data
- dec_rs1  in  5  decode source 1
- dec_rs2  in  5  source 2
- dec_rd  in  5  decode destination
- stall  out  1  decode must hold (combinational)
- rf_we  out  1  to register file cu_rdwrite (registered)
- rf_waddr  out  5  to rd_addr (registered)
- rf_wdata  out  XLEN  to rd_in (registered)
- busy  out  32  scoreboard bit vector, bit 0 always 0

## Operation
- Reset (reset_n low at posedge): rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, FIFO empty. ll_ready=0 while reset_n low, otherwise ll_ready = !fifo_full. Reset mid-operation discards FIFO contents and pending busy bits.
- Write selection each cycle, priority order:
  - alu_valid: register {alu_rd, alu_data}.
  - else FIFO non-empty: pop head, register it.
  - else rf_we=0; rf_waddr and rf_wdata hold.
- rf_we registered as 0 whenever the selected rd is 0. FIFO pop still occurs; the entry is dropped.
- FIFO push on ll_valid && ll_ready. ll_ready depends on full only; no same-cycle push-through when full, even if popping.
- Scoreboard:
  - Set busy[ll_issue_rd] at posedge when ll_issue && ll_issue_rd!=0.
  - Clear busy[r] at the posedge where rf_we=1 and rf_waddr=r are presented, i.e. the edge on which the register file captures.
  - Set and clear of the same bit on one edge: set wins.
- stall = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd] | fifo_full. Index 0 never stalls.
- ll_issue is ignored while stall=1; decode must not assert it.

## Timing
- ALU result: presented at edge N, on rf_* after edge N, captured by register file at edge N+1. Visible on asynchronous reads after N+1.
- Long-latency result: accepted at edge N, earliest write-out after N+1 if no ALU traffic. Each cycle with alu_valid delays FIFO drain by one.
- Busy bit lifetime: from issue edge to RF-capture edge inclusive. A stalled read is released the cycle after the register file is written.
- fifo_full stall prevents new ALU issue, so ALU bubbles guarantee FIFO drain; no starvation.
- FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.

## Structure
- rv32i_pkg: XLEN, REG_ADDR_W=5, NUM_REGS=32, wb_entry struct {rd[4:0], data[XLEN-1:0]}.
- Sub-module wb_fifo: sync FIFO, parameters DEPTH and entry width; push/pop/full/empty; reset_n synchronous.
- Scoreboard and arbiter stay in top level.

## Test plan
- Reset, then alu_valid rd=5 data=0xDEADBEEF -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; busy=0.
- ll_issue rd=7; dec_rs1=7 -> stall=1. ll_valid rd=7 data=0x1234 with no ALU traffic -> rf_we for x7 two cycles later; busy[7] clears at capture edge; stall drops next cycle.
- alu_valid every cycle for 3 cycles while two ll results arrive -> ll_ready=0 after 2 pushes, stall=1. FIFO drains in order after ALU stops.
- ll_issue rd=0 and alu_valid rd=0 -> busy stays 0, rf_we stays 0, FIFO entry popped.
- ll_issue rd=9 on the same edge x9 is captured from an older op -> busy[9]=1 afterwards.
- Assert reset_n=0 with FIFO holding 2 entries and busy=0x00000280 -> all outputs 0, FIFO empty, ll_ready=0 during reset, 1 after.
